student_fir_mc: RTL and testbench

//  Time-multiplexed, multichannel successor of the single-channel student FIR. Holds NUM_CH independent delay

---
 rtl/student_fir_mc_pkg.sv | 35 +++
 rtl/student_fir_mc_mac.sv | 36 +++
 rtl/student_fir_mc.sv | 168 ++++++++++++++++
 tb/tb_student_fir_mc.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/student_fir_mc_pkg.sv
// Shared types and helpers for the multichannel time-multiplexed FIR.
// Holds the FSM state type, the accumulator-width rule and the saturation test.
package student_fir_mc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_MAC   = 2'd2,
    ST_DONE  = 2'd3
  } fir_state_e;

  // Widest value the saturation helper can inspect; OUT_SIZE must stay below this.
  localparam int MAX_W = 128;

  typedef struct packed {
    logic over;
    logic under;
  } sat_flags_t;

  function automatic int acc_width(input int data_w, input int coef_w, input int taps);
    return data_w + coef_w + $clog2(taps);
  endfunction

  // Reports whether v lies above or below the signed range of an out_w-bit result.
  function automatic sat_flags_t saturate(input logic signed [MAX_W-1:0] v, input int out_w);
    logic signed [MAX_W-1:0] hi;
    sat_flags_t f;
    hi = {{(MAX_W-1){1'b0}}, 1'b1};
    hi = (hi <<< (out_w - 1)) - {{(MAX_W-1){1'b0}}, 1'b1};
    f.over  = (v > hi);
    f.under = (v < ~hi);
    return f;
  endfunction

endpackage

// File: rtl/student_fir_mc_mac.sv
// Registered signed multiply-accumulate used sequentially by the FIR.
// clr has priority over en; the accumulator is sized so it can never overflow.
module student_fir_mc_mac #(
  parameter int DATA_SIZE = 16,
  parameter int COEF_SIZE = 16,
  parameter int ACC_W     = 36
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        en,
  input  logic signed [DATA_SIZE-1:0] x,
  input  logic signed [COEF_SIZE-1:0] c,
  output logic signed [ACC_W-1:0]     acc
);

  logic signed [DATA_SIZE+COEF_SIZE-1:0] prod_s;
  logic signed [ACC_W-1:0]               acc_r;

  assign prod_s = x * c;
  assign acc    = acc_r;

  // Accumulator: cleared at the start of a run, adds one product per enabled cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_r <= '0;
    end else if (clr) begin
      acc_r <= '0;
    end else if (en) begin
      acc_r <= acc_r + ACC_W'(prod_s);
    end else begin
      acc_r <= acc_r;
    end
  end

endmodule

// File: rtl/student_fir_mc.sv
// Multichannel FIR: per-channel delay lines, one shared coefficient set and one
// sequential MAC; results are scaled, saturated and tagged with their channel.
module student_fir_mc
  import student_fir_mc_pkg::*;
#(
  parameter int DATA_SIZE = 16,
  parameter int COEF_SIZE = 16,
  parameter int NUM_TAPS  = 16,
  parameter int NUM_CH    = 2,
  parameter int OUT_SIZE  = 32,
  parameter int SHIFT     = 0,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int TAP_W    = $clog2(NUM_TAPS)
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 valid_strobe_in,
  input  logic [CH_W-1:0]      ch_in,
  input  logic [DATA_SIZE-1:0] sample_in,
  output logic                 ready_out,
  input  logic                 coef_we_i,
  input  logic [TAP_W-1:0]     coef_addr_i,
  input  logic [COEF_SIZE-1:0] coef_data_i,
  output logic                 coef_ack_out,
  output logic                 compute_finished_out,
  output logic                 valid_strobe_out,
  output logic [CH_W-1:0]      ch_out,
  output logic [OUT_SIZE-1:0]  y_out,
  output logic                 sat_out,
  output logic                 err_out
);

  localparam int ACC_W = acc_width(DATA_SIZE, COEF_SIZE, NUM_TAPS);
  localparam logic [TAP_W-1:0]    LAST_TAP = TAP_W'(NUM_TAPS - 1);
  localparam logic [OUT_SIZE-1:0] Y_MAX    = {1'b0, {(OUT_SIZE-1){1'b1}}};
  localparam logic [OUT_SIZE-1:0] Y_MIN    = {1'b1, {(OUT_SIZE-1){1'b0}}};

  fir_state_e                  state_r;
  logic [TAP_W-1:0]            tap_r;
  logic [CH_W-1:0]             ch_r;
  logic signed [DATA_SIZE-1:0] sample_r;
  logic signed [DATA_SIZE-1:0] delay_r [NUM_CH][NUM_TAPS];
  logic signed [COEF_SIZE-1:0] coef_r  [NUM_TAPS];

  logic                  ready_r, ack_r, fin_r, vout_r, sat_r, err_r;
  logic [CH_W-1:0]       ch_out_r;
  logic [OUT_SIZE-1:0]   y_r;

  logic                    ch_ok_s, addr_ok_s;
  logic                    mac_clr_s, mac_en_s;
  logic signed [ACC_W-1:0] acc_s, scaled_s;
  logic signed [MAX_W-1:0] wide_s;
  sat_flags_t              flags_s;

  assign ch_ok_s   = (32'(ch_in) < 32'(NUM_CH));
  // Guards tap counts that are not a power of two.
  assign addr_ok_s = (32'(coef_addr_i) < 32'(NUM_TAPS));
  assign mac_clr_s = (state_r == ST_SHIFT);
  assign mac_en_s  = (state_r == ST_MAC);
  assign scaled_s  = acc_s >>> SHIFT;
  assign wide_s    = MAX_W'(scaled_s);
  assign flags_s   = saturate(wide_s, OUT_SIZE);

  student_fir_mc_mac #(
    .DATA_SIZE (DATA_SIZE),
    .COEF_SIZE (COEF_SIZE),
    .ACC_W     (ACC_W)
  ) u_mac (
    .clk (clk_i),
    .rst (rst_i),
    .clr (mac_clr_s),
    .en  (mac_en_s),
    .x   (delay_r[ch_r][tap_r]),
    .c   (coef_r[tap_r]),
    .acc (acc_s)
  );

  assign ready_out            = ready_r;
  assign coef_ack_out         = ack_r;
  assign compute_finished_out = fin_r;
  assign valid_strobe_out     = vout_r;
  assign ch_out               = ch_out_r;
  assign y_out                = y_r;
  assign sat_out              = sat_r;
  assign err_out              = err_r;

  // Control FSM, delay lines, coefficient bank and registered result outputs.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r  <= ST_IDLE;
      tap_r    <= '0;
      ch_r     <= '0;
      sample_r <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < NUM_TAPS; k++) begin
          delay_r[c][k] <= '0;
        end
      end
      for (int k = 0; k < NUM_TAPS; k++) begin
        coef_r[k] <= '0;
      end
      ready_r  <= 1'b1;
      ack_r    <= 1'b0;
      fin_r    <= 1'b0;
      vout_r   <= 1'b0;
      sat_r    <= 1'b0;
      err_r    <= 1'b0;
      ch_out_r <= '0;
      y_r      <= '0;
    end else begin
      ack_r  <= 1'b0;
      fin_r  <= 1'b0;
      vout_r <= 1'b0;
      err_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (valid_strobe_in && ch_ok_s) begin
            ch_r     <= ch_in;
            sample_r <= sample_in;
            ready_r  <= 1'b0;
            state_r  <= ST_SHIFT;
          end else begin
            // A strobe reaching here carries a bad channel; a coefficient write may still land.
            err_r <= valid_strobe_in;
            if (coef_we_i && addr_ok_s) begin
              coef_r[coef_addr_i] <= coef_data_i;
              ack_r               <= 1'b1;
            end
          end
        end
        ST_SHIFT: begin
          for (int k = NUM_TAPS - 1; k > 0; k--) begin
            delay_r[ch_r][k] <= delay_r[ch_r][k-1];
          end
          delay_r[ch_r][0] <= sample_r;
          tap_r            <= '0;
          state_r          <= ST_MAC;
        end
        ST_MAC: begin
          tap_r <= tap_r + 1'b1;
          if (tap_r == LAST_TAP) begin
            fin_r   <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (flags_s.over) begin
            y_r <= Y_MAX;
          end else if (flags_s.under) begin
            y_r <= Y_MIN;
          end else begin
            y_r <= wide_s[OUT_SIZE-1:0];
          end
          sat_r    <= flags_s.over | flags_s.under;
          ch_out_r <= ch_r;
          vout_r   <= 1'b1;
          ready_r  <= 1'b1;
          state_r  <= ST_IDLE;
        end
        default: begin
          ready_r <= 1'b1;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_student_fir_mc.sv
// Scoreboard bench for student_fir_mc: a plain-arithmetic FIR model predicts each
// result; a negedge monitor compares whatever the DUT emits against the queue.
module tb_student_fir_mc;

  localparam int NT  = 16;
  localparam int NC  = 3;
  localparam int OS  = 16;
  localparam int LAT = NT + 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_in = 1'b0;
  logic [1:0]  ch_in = 2'd0;
  logic [15:0] sample_in = 16'd0;
  logic        ready_out;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = 4'd0;
  logic [15:0] coef_data = 16'd0;
  logic        coef_ack, fin, valid_out, sat_out, err_out;
  logic [1:0]  ch_out;
  logic [15:0] y_out;

  student_fir_mc #(
    .DATA_SIZE (16), .COEF_SIZE (16), .NUM_TAPS (NT),
    .NUM_CH (NC), .OUT_SIZE (OS), .SHIFT (0)
  ) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .valid_strobe_in      (valid_in),
    .ch_in                (ch_in),
    .sample_in            (sample_in),
    .ready_out            (ready_out),
    .coef_we_i            (coef_we),
    .coef_addr_i          (coef_addr),
    .coef_data_i          (coef_data),
    .coef_ack_out         (coef_ack),
    .compute_finished_out (fin),
    .valid_strobe_out     (valid_out),
    .ch_out               (ch_out),
    .y_out                (y_out),
    .sat_out              (sat_out),
    .err_out              (err_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    int     ch;
    longint y;
    bit     sat;
    longint acc_cyc;
  } exp_t;

  exp_t   expq[$];
  exp_t   mon_e;
  int     total = 0;
  int     bad = 0;
  longint cyc = 0;
  int     hist[NC][NT];
  int     coef[NT];
  logic   prev_fin = 1'b0;

  function automatic void check(string name, longint act, longint req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: shift the channel history, dot-product with coefficients, clip.
  function automatic void model_accept(int ch, int s);
    exp_t   e;
    longint sum = 0;
    longint hi = (longint'(1) << (OS - 1)) - 1;
    longint lo = -(longint'(1) << (OS - 1));
    for (int k = NT - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
    hist[ch][0] = s;
    for (int k = 0; k < NT; k++) sum += longint'(hist[ch][k]) * longint'(coef[k]);
    e.ch = ch;
    e.sat = 1'b0;
    e.y = sum;
    if (sum > hi) begin e.y = hi; e.sat = 1'b1; end
    if (sum < lo) begin e.y = lo; e.sat = 1'b1; end
    e.acc_cyc = cyc + 1;
    expq.push_back(e);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NC; c++)
      for (int k = 0; k < NT; k++) hist[c][k] = 0;
    for (int k = 0; k < NT; k++) coef[k] = 0;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: every emitted result must match the oldest outstanding prediction.
  always @(negedge clk) begin
    if (valid_out) begin
      if (expq.size() == 0) begin
        check("unexpected_valid", 1, 0);
      end else begin
        mon_e = expq.pop_front();
        check("ch_out", longint'(ch_out), mon_e.ch);
        check("y_out", longint'($signed(y_out)), mon_e.y);
        check("sat_out", longint'(sat_out), longint'(mon_e.sat));
        check("latency", cyc - mon_e.acc_cyc, LAT);
        check("finished_before_valid", longint'(prev_fin), 1);
      end
    end
    prev_fin <= fin;
  end

  task automatic wait_ready();
    for (int i = 0; i < 200 && !ready_out; i++) @(negedge clk);
    if (!ready_out) check("ready_timeout", 0, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 600 && (expq.size() != 0 || !ready_out); i++) @(negedge clk);
    check("drain_pending", expq.size(), 0);
  endtask

  task automatic send(int ch, int s);
    wait_ready();
    valid_in  = 1'b1;
    ch_in     = 2'(ch);
    sample_in = 16'(s);
    if (ch < NC) model_accept(ch, s);
    @(negedge clk);
    valid_in = 1'b0;
    if (ch >= NC) begin
      check("err_out_bad_ch", longint'(err_out), 1);
      check("ready_bad_ch", longint'(ready_out), 1);
    end
  endtask

  task automatic write_coef(int a, int d, bit exp_ack);
    coef_we   = 1'b1;
    coef_addr = 4'(a);
    coef_data = 16'(d);
    @(negedge clk);
    coef_we = 1'b0;
    check("coef_ack", longint'(coef_ack), longint'(exp_ack));
    if (exp_ack) coef[a] = int'($signed(16'(d)));
  endtask

  task automatic load_coefs_idle(int base, int step);
    for (int k = 0; k < NT; k++) begin
      wait_ready();
      write_coef(k, base + step * k, 1'b1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", longint'(ready_out), 1);
    check("reset_valid", longint'(valid_out), 0);
    check("reset_y", longint'(y_out), 0);
    check("reset_sat", longint'(sat_out), 0);
    check("reset_err", longint'(err_out), 0);
    check("reset_ack", longint'(coef_ack), 0);

    // Impulse response through c[k]=k+1.
    load_coefs_idle(1, 1);
    send(0, 1);
    for (int i = 0; i < NT; i++) send(0, 0);
    wait_drain();

    // Channel isolation: ch0 impulse interleaved with ch1 zeros.
    send(0, 100);
    send(1, 0);
    for (int i = 0; i < NT - 1; i++) begin
      send(0, 0);
      send(1, 0);
    end
    wait_drain();

    // Coefficient write while busy is ignored, retried in idle is accepted.
    send(0, 7);
    repeat (5) @(negedge clk);
    write_coef(0, 5, 1'b0);
    wait_drain();
    write_coef(0, 5, 1'b1);
    send(0, 3);
    wait_drain();

    // Sample and write in the same idle cycle: sample wins, no ack.
    wait_ready();
    valid_in  = 1'b1; ch_in = 2'd2; sample_in = 16'd3;
    coef_we   = 1'b1; coef_addr = 4'd1; coef_data = 16'd99;
    model_accept(2, 3);
    @(negedge clk);
    valid_in = 1'b0; coef_we = 1'b0;
    check("coef_ack_vs_sample", longint'(coef_ack), 0);
    wait_drain();

    // Strobes while busy are ignored; bad channel is rejected with err_out.
    send(1, 50);
    valid_in = 1'b1; ch_in = 2'd1; sample_in = 16'd1234;
    repeat (2) @(negedge clk);
    valid_in = 1'b0;
    wait_drain();
    send(3, 77);
    @(negedge clk);
    check("err_single_pulse", longint'(err_out), 0);
    wait_drain();

    // Randomized traffic with occasional coefficient rewrites.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        wait_ready();
        write_coef(int'($urandom_range(0, NT - 1)), int'($urandom_range(0, 80)) - 40, 1'b1);
      end
      send(int'($urandom_range(0, NC)), int'($urandom_range(0, 511)) - 256);
    end
    wait_drain();

    // Saturation both ways with full-scale coefficients and samples.
    load_coefs_idle(32767, 0);
    for (int i = 0; i < 4; i++) send(2, 32767);
    for (int i = 0; i < NT; i++) send(2, -32767);
    wait_drain();

    // Reset during MAC tap 7: no result, everything cleared.
    send(0, 9);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    expq.delete();
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_mid_ready", longint'(ready_out), 1);
    check("rst_mid_y", longint'(y_out), 0);
    check("rst_mid_sat", longint'(sat_out), 0);
    send(0, 1);
    for (int i = 0; i < 3; i++) send(0, 0);
    wait_drain();

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
